acc_control_fsm: RTL

- Multicycle control unit for the 16-bit accumulator CPU. It is the initiator on the PC-control interface; the program-counter block consumes its PCWrite, Branch, bneOrbeq and PCSrc outputs.
- It sequences fetch, decode, memory access, accumulator writeback, branch and jump from the 5-bit opcode in IR[15:11].
- It also drives the remaining datapath enables.
- It honours a memory-ready handshake on every memory access.

---
 rtl/acc_control_fsm.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the 16-bit accumulator CPU.
// Sequences fetch, decode, memory access, accumulator writeback, branch and
// jump from the 5-bit opcode, and drives the PC-control interface
// (PCWrite/Branch/bneOrbeq/PCSrc) plus the remaining datapath enables.
// Outputs are a Moore decode of the state register and Opcode; the only
// exception is the FETCH handshake, where IRWrite/PCWrite follow MemReady
// so that the IR and PC are loaded exactly in the cycle memory delivers.
module acc_control_fsm #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] HALT_OP = {OPW{1'b1}}
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           Branch,
  output logic           bneOrbeq,
  output logic [1:0]     PCSrc,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           AccWrite,
  output logic [1:0]     AccSrc,
  output logic           RAWrite,
  output logic           Illegal,
  output logic           Halted
);

  // Opcode map
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(4);
  localparam logic [OPW-1:0] OP_STORE = OPW'(5);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6);
  localparam logic [OPW-1:0] OP_LI    = OPW'(7);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(8);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(9);
  localparam logic [OPW-1:0] OP_J     = OPW'(10);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(11);
  localparam logic [OPW-1:0] OP_JR    = OPW'(12);

  // PCSrc encodings
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b01;
  localparam logic [1:0] PC_BR   = 2'b10;
  localparam logic [1:0] PC_RA   = 2'b11;

  // ALUSrcB encodings
  localparam logic [1:0] B_IMM   = 2'b00;
  localparam logic [1:0] B_TWO   = 2'b01;
  localparam logic [1:0] B_MDR   = 2'b10;
  localparam logic [1:0] B_BOFF  = 2'b11;

  // AccSrc encodings
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_MDR = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_ACCWB,
    S_MEMWR,
    S_IMM,
    S_BR,
    S_JMP,
    S_HALT
  } state_t;

  state_t state;

  // Opcode classification
  logic op_alu, op_load, op_store, op_imm, op_br, op_jmp, op_halt, op_legal;

  assign op_alu   = (Opcode <= OP_OR);
  assign op_load  = (Opcode == OP_LOAD);
  assign op_store = (Opcode == OP_STORE);
  assign op_imm   = (Opcode == OP_ADDI) || (Opcode == OP_LI);
  assign op_br    = (Opcode == OP_BEQ) || (Opcode == OP_BNE);
  assign op_jmp   = (Opcode == OP_J) || (Opcode == OP_JAL) || (Opcode == OP_JR);
  assign op_halt  = (Opcode == HALT_OP);
  assign op_legal = op_alu || op_load || op_store || op_imm || op_br || op_jmp;

  // State sequencing; reset aborts any access in progress and restarts at FETCH
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          // HALT_OP is checked first so a re-parameterised halt code wins
          if (op_halt)                 state <= S_HALT;
          else if (op_alu || op_load)  state <= S_MEMRD;
          else if (op_store)           state <= S_MEMWR;
          else if (op_imm)             state <= S_IMM;
          else if (op_br)              state <= S_BR;
          else if (op_jmp)             state <= S_JMP;
          else                         state <= S_FETCH;
        end
        S_MEMRD:  if (MemReady) state <= S_ACCWB;
        S_ACCWB:  state <= S_FETCH;
        S_MEMWR:  if (MemReady) state <= S_FETCH;
        S_IMM:    state <= S_FETCH;
        S_BR:     state <= S_FETCH;
        S_JMP:    state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Ungated control decode
  logic       pc_write_dec, branch_dec, bne_or_beq_dec, iord_dec;
  logic       mem_read_dec, mem_write_dec, ir_write_dec, alu_src_a_dec;
  logic       acc_write_dec, ra_write_dec, illegal_dec, halted_dec;
  logic [1:0] pc_src_dec, alu_src_b_dec, acc_src_dec;
  logic [2:0] alu_op_dec;

  // Per-state output decode; anything not set for a state stays 0
  always_comb begin
    pc_write_dec   = 1'b0;
    branch_dec     = 1'b0;
    bne_or_beq_dec = 1'b0;
    pc_src_dec     = PC_INC;
    iord_dec       = 1'b0;
    mem_read_dec   = 1'b0;
    mem_write_dec  = 1'b0;
    ir_write_dec   = 1'b0;
    alu_src_a_dec  = 1'b0;
    alu_src_b_dec  = B_IMM;
    alu_op_dec     = ALU_ADD;
    acc_write_dec  = 1'b0;
    acc_src_dec    = ACC_ALU;
    ra_write_dec   = 1'b0;
    illegal_dec    = 1'b0;
    halted_dec     = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+2 is computed and latched together with the IR on the ready cycle
        mem_read_dec  = 1'b1;
        ir_write_dec  = MemReady;
        alu_src_b_dec = B_TWO;
        pc_write_dec  = MemReady;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while dispatching
        alu_src_b_dec = B_BOFF;
        illegal_dec   = !(op_halt || op_legal);
      end
      S_MEMRD: begin
        mem_read_dec = 1'b1;
        iord_dec     = 1'b1;
      end
      S_ACCWB: begin
        acc_write_dec = 1'b1;
        alu_src_a_dec = 1'b1;
        alu_src_b_dec = B_MDR;
        alu_op_dec    = {1'b0, Opcode[1:0]};
        acc_src_dec   = op_load ? ACC_MDR : ACC_ALU;
      end
      S_MEMWR: begin
        // Write request held for the whole wait so memory sees a stable access
        mem_write_dec = 1'b1;
        iord_dec      = 1'b1;
      end
      S_IMM: begin
        acc_write_dec = 1'b1;
        if (Opcode == OP_LI) begin
          acc_src_dec = ACC_IMM;
        end else begin
          alu_src_a_dec = 1'b1;
          alu_src_b_dec = B_IMM;
          alu_op_dec    = ALU_ADD;
          acc_src_dec   = ACC_ALU;
        end
      end
      S_BR: begin
        // PC block qualifies the load with Zero; no unconditional write here
        branch_dec     = 1'b1;
        pc_src_dec     = PC_BR;
        bne_or_beq_dec = (Opcode == OP_BEQ);
      end
      S_JMP: begin
        pc_write_dec = 1'b1;
        pc_src_dec   = (Opcode == OP_JR) ? PC_RA : PC_JUMP;
        // RA captures the PC already advanced during FETCH
        ra_write_dec = (Opcode == OP_JAL);
      end
      S_HALT: begin
        halted_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset forces every output low immediately, FETCH outputs included
  assign PCWrite  = reset & pc_write_dec;
  assign Branch   = reset & branch_dec;
  assign bneOrbeq = reset & bne_or_beq_dec;
  assign PCSrc    = reset ? pc_src_dec : 2'b00;
  assign IorD     = reset & iord_dec;
  assign MemRead  = reset & mem_read_dec;
  assign MemWrite = reset & mem_write_dec;
  assign IRWrite  = reset & ir_write_dec;
  assign ALUSrcA  = reset & alu_src_a_dec;
  assign ALUSrcB  = reset ? alu_src_b_dec : 2'b00;
  assign ALUOp    = reset ? alu_op_dec : 3'b000;
  assign AccWrite = reset & acc_write_dec;
  assign AccSrc   = reset ? acc_src_dec : 2'b00;
  assign RAWrite  = reset & ra_write_dec;
  assign Illegal  = reset & illegal_dec;
  assign Halted   = reset & halted_dec;

  // Structural guarantees of the control encoding
  a_pcw_branch_excl: assert property (@(posedge CLK) disable iff (!reset)
    !(PCWrite && Branch));

  a_mem_rw_excl: assert property (@(posedge CLK) disable iff (!reset)
    !(MemRead && MemWrite));

  // A taken branch is always a separate PC write from the unconditional one
  a_taken_branch_alone: assert property (@(posedge CLK) disable iff (!reset)
    (Branch && (bneOrbeq ? Zero : !Zero)) |-> !PCWrite);

  a_halt_quiet: assert property (@(posedge CLK) disable iff (!reset)
    Halted |-> !(PCWrite || Branch || MemRead || MemWrite || IRWrite ||
                 AccWrite || RAWrite || Illegal));

endmodule
